// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   DATA_BITS  : payload bits per frame (8N1)
//   rx_state_t : receiver FSM states
//   majority3  : 2-of-3 vote used to de-glitch each bit sample
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchronizer for a single asynchronous input.
//   clk    in  : destination clock
//   rst_n  in  : asynchronous active-low reset
//   d      in  : asynchronous input
//   q      out : d resynchronized to clk (2-cycle latency)
// RST_VAL sets the value both flops take in reset, so a pin that idles
// high does not look like an edge when reset is released.
`timescale 1ns/1ps
module bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receive.sv
// uart_receive: 8N1 UART receiver with 3-sample majority voting.
//   CLKS_PER_BIT  : Clk cycles per bit (>= 8)
//   Clk           in  : clock, rising edge
//   reset         in  : asynchronous active-low reset
//   Serial        in  : asynchronous RX line, idles high
//   Data          out : last good byte, held until the next good frame
//   R_Done        out : one-cycle strobe, Data valid in the same cycle
//   Frame_Error   out : one-cycle strobe when the stop bit reads 0
//   Busy          out : high whenever the FSM is not in IDLE
`timescale 1ns/1ps
module uart_receive
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic                 Serial,
   output logic [DATA_BITS-1:0] Data,
   output logic                 R_Done,
   output logic                 Frame_Error,
   output logic                 Busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] SMP0 = CW'(HALF - 1);
   localparam logic [CW-1:0] SMP1 = CW'(HALF);
   localparam logic [CW-1:0] DEC  = CW'(HALF + 1);   // third sample + decision
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           smp;
   logic                 rx_s;
   logic                 vote;

   bit_sync #(.RST_VAL(1'b1)) u_sync (
      .clk   (Clk),
      .rst_n (reset),
      .d     (Serial),
      .q     (rx_s)
   );

   // Third sample is the live rx_s at the decision count.
   assign vote = majority3(smp[0], smp[1], rx_s);
   assign Busy = (state != IDLE);

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         smp         <= '0;
         Data        <= '0;
         R_Done      <= 1'b0;
         Frame_Error <= 1'b0;
      end else begin
         R_Done      <= 1'b0;
         Frame_Error <= 1'b0;

         // Bit timer and early samples run only while inside a frame.
         if (state == START || state == DATA || state == STOP) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (cnt == SMP0) smp[0] <= rx_s;
            if (cnt == SMP1) smp[1] <= rx_s;
         end

         case (state)
            IDLE: begin
               cnt <= '0;
               // The detecting cycle counts as cycle 0 of the start bit.
               if (!rx_s) begin
                  state <= START;
                  cnt   <= CW'(1);
               end
            end
            START: begin
               if (cnt == DEC && vote) begin
                  // Start bit did not hold low: glitch, drop back quietly.
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (cnt == DEC)
                  shreg <= {vote, shreg[DATA_BITS-1:1]};
               if (cnt == LAST) begin
                  if (bit_idx == LAST_BIT)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end
            end
            STOP: begin
               if (cnt == DEC) begin
                  cnt <= '0;
                  if (vote) begin
                     // Leave mid stop bit so a back-to-back start edge is caught.
                     Data   <= shreg;
                     R_Done <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     Frame_Error <= 1'b1;
                     state       <= BREAK;
                  end
               end
            end
            BREAK: begin
               // Hold here for the whole low period so a break reports once.
               cnt <= '0;
               if (rx_s) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
